// File: rtl/data_mem_responder.sv
// Word-addressed data memory behind a valid/ready request channel and a
// valid/ready response channel. Each accepted request is held for a fixed
// LATENCY before the access is made and the result is presented until the
// initiator takes it. Misaligned or out-of-range addresses return an error.
module data_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
    localparam logic [32:0] LIMIT    = 33'(4 * DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t      state;
    logic [3:0]  cnt;

    // Captured request; only these copies are used once the request is taken
    logic        h_write;
    logic [31:0] h_addr;
    logic [31:0] h_wdata;
    logic [3:0]  h_wstrb;

    // Storage: the array itself is never reset. A per-word flag marks words
    // written since the last reset, so a reset clears the whole memory in a
    // single edge without touching every word.
    logic [31:0]      mem [DEPTH];
    logic [DEPTH-1:0] word_vld;

    logic [AW-1:0] word_idx;
    logic [31:0]   cur_word;
    logic          acc_err;
    logic          access;
    logic          do_write;

    // Replace the enabled byte lanes of a word with the new store data
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) begin
                res[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Misaligned or beyond the last stored byte
    function automatic logic addr_error(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || ({1'b0, addr} >= LIMIT);
    endfunction

    assign word_idx  = h_addr[AW+1:2];
    assign cur_word  = word_vld[word_idx] ? mem[word_idx] : 32'h0;
    assign acc_err   = addr_error(h_addr);
    assign access    = (state == BUSY) && (cnt == 4'd0);
    // Gated by rst so a reset on the access edge drops a pending store
    assign do_write  = rst && access && h_write && !acc_err;
    assign req_ready = rst && (state == IDLE);

    // Control FSM: capture, count down the latency, present the response
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        h_write <= req_write;
                        h_addr  <= req_addr;
                        h_wdata <= req_wdata;
                        h_wstrb <= req_wstrb;
                        cnt     <= CNT_INIT;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= acc_err;
                        resp_rdata <= (acc_err || h_write) ? 32'h0 : cur_word;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        resp_rdata <= 32'h0;
                        resp_err   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Written-word flags; cleared by reset, set by any non-error store
    always_ff @(posedge clk) begin
        if (!rst) begin
            word_vld <= '0;
        end else if (do_write) begin
            word_vld[word_idx] <= 1'b1;
        end
    end

    // Data array: byte-lane merge on a non-error store
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[word_idx] <= merge_bytes(cur_word, h_wdata, h_wstrb);
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (DEPTH=256, LATENCY=2).
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int checks = 0;
    int passes = 0;

    data_mem_responder #(.DEPTH(256), .LATENCY(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_req();
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        req_wstrb = 4'h0;
    endtask

    // One full transaction with resp_ready high; lat = edges from acceptance
    // to resp_valid, or -1 if the response never arrived.
    task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd,
                        output logic e, output int lat);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_wstrb = s;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        tick();
        drop_req();
        lat = 0;
        while (!resp_valid && lat < 20) begin
            tick();
            lat++;
        end
        rd = resp_rdata;
        e  = resp_err;
        if (!resp_valid) lat = -1;
        else tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        checks++; if (req_ready !== 1'b0) $display("FAIL reset_req_ready: got %b want 0", req_ready); else passes++;
        checks++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b want 0", resp_valid); else passes++;
        checks++; if (resp_rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 00000000", resp_rdata); else passes++;
        checks++; if (resp_err !== 1'b0) $display("FAIL reset_err: got %b want 0", resp_err); else passes++;
        rst = 1'b1;
        tick();
        checks++; if (req_ready !== 1'b1) $display("FAIL idle_req_ready: got %b want 1", req_ready); else passes++;
    endtask

    task automatic test_load_after_reset();
        logic [31:0] rd; logic e; int lat;
        xact(1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat);
        checks++; if (lat !== 2) $display("FAIL load_latency: got %0d want 2", lat); else passes++;
        checks++; if (rd !== 32'h0) $display("FAIL load_0x10_rdata: got %h want 00000000", rd); else passes++;
        checks++; if (e !== 1'b0) $display("FAIL load_0x10_err: got %b want 0", e); else passes++;
        checks++; if (resp_valid !== 1'b0) $display("FAIL post_handshake_valid: got %b want 0", resp_valid); else passes++;
        checks++; if (resp_rdata !== 32'h0) $display("FAIL post_handshake_rdata: got %h want 00000000", resp_rdata); else passes++;
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic e; int lat;
        xact(1'b1, 32'h20, 32'hDEADBEEF, 4'hF, rd, e, lat);
        checks++; if (rd !== 32'h0) $display("FAIL store_rdata: got %h want 00000000", rd); else passes++;
        checks++; if (e !== 1'b0) $display("FAIL store_err: got %b want 0", e); else passes++;
        checks++; if (lat !== 2) $display("FAIL store_latency: got %0d want 2", lat); else passes++;
        xact(1'b0, 32'h20, 32'h0, 4'h0, rd, e, lat);
        checks++; if (rd !== 32'hDEADBEEF) $display("FAIL load_full_word: got %h want deadbeef", rd); else passes++;
    endtask

    task automatic test_partial();
        logic [31:0] rd; logic e; int lat;
        xact(1'b1, 32'h20, 32'h000000AA, 4'b0001, rd, e, lat);
        xact(1'b1, 32'h20, 32'h55000000, 4'b1000, rd, e, lat);
        xact(1'b0, 32'h20, 32'h0, 4'hF, rd, e, lat);
        checks++; if (rd !== 32'h55ADBEAA) $display("FAIL partial_store: got %h want 55adbeaa", rd); else passes++;
        // Empty strobe: legal no-op store
        xact(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, rd, e, lat);
        checks++; if (e !== 1'b0) $display("FAIL noop_store_err: got %b want 0", e); else passes++;
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic e; int lat;
        xact(1'b0, 32'h22, 32'h0, 4'h0, rd, e, lat);
        checks++; if (e !== 1'b1) $display("FAIL misaligned_load_err: got %b want 1", e); else passes++;
        checks++; if (rd !== 32'h0) $display("FAIL misaligned_load_rdata: got %h want 00000000", rd); else passes++;
        checks++; if (lat !== 2) $display("FAIL error_latency: got %0d want 2", lat); else passes++;
        xact(1'b1, 32'h400, 32'h12345678, 4'hF, rd, e, lat);
        checks++; if (e !== 1'b1) $display("FAIL range_store_err: got %b want 1", e); else passes++;
        checks++; if (rd !== 32'h0) $display("FAIL range_store_rdata: got %h want 00000000", rd); else passes++;
        xact(1'b1, 32'h21, 32'hFFFFFFFF, 4'hF, rd, e, lat);
        checks++; if (e !== 1'b1) $display("FAIL misaligned_store_err: got %b want 1", e); else passes++;
        xact(1'b0, 32'h0, 32'h0, 4'h0, rd, e, lat);
        checks++; if (rd !== 32'h0) $display("FAIL no_wrap_rdata: got %h want 00000000", rd); else passes++;
        checks++; if (e !== 1'b0) $display("FAIL no_wrap_err: got %b want 0", e); else passes++;
        xact(1'b0, 32'h3FC, 32'h0, 4'h0, rd, e, lat);
        checks++; if (e !== 1'b0) $display("FAIL last_word_err: got %b want 0", e); else passes++;
    endtask

    task automatic test_backpressure();
        int n;
        resp_ready = 1'b0;
        n = 0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h20; req_wstrb = 4'h0;
        while (!req_ready && n < 20) begin tick(); n++; end
        tick();
        drop_req();
        n = 0;
        while (!resp_valid && n < 20) begin tick(); n++; end
        checks++; if (n !== 2) $display("FAIL stall_latency: got %0d want 2", n); else passes++;
        for (int i = 0; i < 5; i++) begin
            checks++; if (resp_valid !== 1'b1) $display("FAIL stall_valid[%0d]: got %b want 1", i, resp_valid); else passes++;
            checks++; if (resp_rdata !== 32'h55ADBEAA) $display("FAIL stall_rdata[%0d]: got %h want 55adbeaa", i, resp_rdata); else passes++;
            checks++; if (req_ready !== 1'b0) $display("FAIL stall_req_ready[%0d]: got %b want 0", i, req_ready); else passes++;
            if (i == 1) begin
                req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_wstrb = 4'h0;
            end
            tick();
        end
        resp_ready = 1'b1;
        tick();
        checks++; if (req_ready !== 1'b1) $display("FAIL after_stall_ready: got %b want 1", req_ready); else passes++;
        checks++; if (resp_valid !== 1'b0) $display("FAIL after_stall_valid: got %b want 0", resp_valid); else passes++;
        tick();
        checks++; if (req_ready !== 1'b0) $display("FAIL held_req_accepted: got %b want 0", req_ready); else passes++;
        drop_req();
        n = 0;
        while (!resp_valid && n < 20) begin tick(); n++; end
        checks++; if (n !== 2) $display("FAIL held_req_latency: got %0d want 2", n); else passes++;
        checks++; if (resp_rdata !== 32'h0) $display("FAIL held_req_rdata: got %h want 00000000", resp_rdata); else passes++;
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_wstrb = 4'h0;
        n = 0;
        while (!req_ready && n < 20) begin tick(); n++; end
        tick();
        n = 0;
        while (!req_ready && n < 20) begin tick(); n++; end
        tick();
        n++;
        checks++; if (n !== 4) $display("FAIL req_spacing: got %0d want 4", n); else passes++;
        drop_req();
        n = 0;
        while (!resp_valid && n < 20) begin tick(); n++; end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic e; int lat; int n;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30;
        req_wdata = 32'hFFFFFFFF; req_wstrb = 4'hF;
        n = 0;
        while (!req_ready && n < 20) begin tick(); n++; end
        tick();
        drop_req();
        tick();
        // Next edge would perform the store
        rst = 1'b0;
        tick();
        checks++; if (resp_valid !== 1'b0) $display("FAIL midreset_valid: got %b want 0", resp_valid); else passes++;
        checks++; if (req_ready !== 1'b0) $display("FAIL midreset_req_ready: got %b want 0", req_ready); else passes++;
        tick();
        checks++; if (resp_valid !== 1'b0) $display("FAIL midreset_valid2: got %b want 0", resp_valid); else passes++;
        rst = 1'b1;
        xact(1'b0, 32'h30, 32'h0, 4'h0, rd, e, lat);
        checks++; if (rd !== 32'h0) $display("FAIL aborted_store_rdata: got %h want 00000000", rd); else passes++;
        checks++; if (lat !== 2) $display("FAIL postreset_latency: got %0d want 2", lat); else passes++;
        xact(1'b0, 32'h20, 32'h0, 4'h0, rd, e, lat);
        checks++; if (rd !== 32'h0) $display("FAIL mem_cleared: got %h want 00000000", rd); else passes++;
    endtask

    initial begin
        rst        = 1'b0;
        resp_ready = 1'b1;
        drop_req();
        test_reset();
        test_load_after_reset();
        test_store_load();
        test_partial();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
